bist_sig_controller: RTL
========================

// Module: bist_sig_controller
// PURPOSE
// - BIST sequencer for the pipelined multiplier datapath. It generates LFSR stimulus for the
//   circuit under test and clears the downstream 8-bit MISR.
// - After all patterns plus pipeline drain, it samples the MISR signature and compares it with
//   a golden value.
// - Sits between the system start/status interface and the misr_8bit instance.
// PARAMETERS
// - NUM_PATTERNS  256    patterns issued per run; legal range >= 1
// - PIPE_LAT      3      CUT+MISR latency in cycles to drain after the last pattern; 0 = no drain
// - SEED          8'h01  LFSR start value; 8'h00 is replaced by 8'h01
// - GOLDEN_SIG    8'h00  expected MISR signature at compare time
// PORTS
// - clk            in   1  system clock, rising edge
// - rst            in   1  asynchronous, active-high reset
// - start          in   1  run request, sampled each cycle; ignored unless in IDLE or DONE
// - misr_sig       in   8  MISR output from misr_8bit
// - pattern        out  8  stimulus to CUT; 8'h00 outside RUN
// - pattern_valid  out  1  high exactly in RUN cycles
// - misr_clr       out  1  registered one-cycle pulse, glitch-free; ORed into MISR rst by integration
// - busy           out  1  high in CLEAR/RUN/FLUSH/COMPARE
// - done           out  1  high in DONE
// - pass           out  1  compare result; valid while done=1
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; lfsr=SEED (or 8'h01 if SEED=0); counter=0.
// - All outputs are registered.
// - FSM states:
//   - IDLE: start=1 -> CLEAR.
//   - CLEAR (1 cycle): misr_clr=1; lfsr<=seed; cnt<=0 -> RUN.
//   - RUN: pattern=lfsr, pattern_valid=1. Each cycle the LFSR advances and cnt increments.
//     After NUM_PATTERNS cycles -> FLUSH, or -> COMPARE if PIPE_LAT=0.
//   - FLUSH: pattern=0, pattern_valid=0 for PIPE_LAT cycles -> COMPARE.
//   - COMPARE (1 cycle): pass <= (misr_sig == GOLDEN_SIG) -> DONE.
//   - DONE: done=1; pass is held. start=1 -> CLEAR, with done and pass cleared that same cycle.
// - LFSR: Fibonacci x^8+x^6+x^5+x^4+1. fb = l[7]^l[5]^l[4]^l[3]; next = {l[6:0], fb}.
//   - From 8'h01 the sequence is 01,02,04,08,11,...
//   - The LFSR never reaches 0; the period is 255, so it wraps when NUM_PATTERNS > 255.
// - Counters: width $clog2(NUM_PATTERNS+1) for the pattern count, $clog2(PIPE_LAT+1) for drain.
//   Both saturate-free and are cleared on each state entry.
// - Timing: start sampled at edge k puts misr_clr high in cycle k+1. The first pattern appears
//   in cycle k+2. done rises NUM_PATTERNS+PIPE_LAT+2 cycles after CLEAR.
// - start while busy=1 is ignored (no restart, no abort).
// - rst mid-run aborts immediately to reset values. misr_clr is not pulsed; the MISR clears via
//   its own rst.
// CONFIGURATION
// - BIST_SIG_CAPTURE_EN defined:
//   - Adds output sig_captured [7:0], loaded with misr_sig in COMPARE and held through DONE.
//   - Reset value 8'h00; cleared on entry to CLEAR.
// - BIST_SIG_CAPTURE_EN undefined: no sig_captured port and no capture register. Everything
//   else is identical.
// TESTING
// - Reset: rst=1 for 3 cycles, mid-cycle deassert -> all outputs 0, state IDLE, start ignored
//   during rst.
// - Sequence (SEED=01, NUM_PATTERNS=5, PIPE_LAT=2): single-cycle start pulse -> misr_clr for
//   1 cycle, then pattern = 01,02,04,08,11 with pattern_valid=1. Then 2 cycles of pattern=0,
//   then done=1 exactly 9 cycles after misr_clr.
// - Pass/fail with bench-driven misr_sig, GOLDEN_SIG=8'hA5:
//   - misr_sig=8'hA5 at COMPARE -> pass=1.
//   - Rerun with misr_sig=8'hA4 -> pass=0, done=1.
// - Integrated with misr_8bit, GOLDEN_SIG taken from a bench reference model of the CUT+MISR:
//   - Clean run -> pass=1.
//   - Force one CUT output bit for one cycle -> pass=0.
// - Boundaries:
//   - start held high through a whole run -> no restart while busy, immediate restart from DONE.
//   - PIPE_LAT=0 -> COMPARE follows the last pattern directly.
//   - SEED=0 -> first pattern 8'h01.
// - Abort: rst asserted mid-RUN -> pattern=0 and busy=0 immediately. A new start then gives a
//   full run from the seed.
// - With BIST_SIG_CAPTURE_EN: sig_captured equals misr_sig at COMPARE (8'hA5) and holds through
//   DONE. It reads 8'h00 after a new start.

Source files
------------

// File: rtl/bist_sig_controller.sv
// BIST sequencer: drives LFSR patterns into the multiplier CUT, clears the MISR and checks its signature.
// Optional define BIST_SIG_CAPTURE_EN adds the sig_captured output holding the signature read at compare.
module bist_sig_controller #(
    parameter int          NUM_PATTERNS = 256,
    parameter int          PIPE_LAT     = 3,
    parameter logic [7:0]  SEED         = 8'h01,
    parameter logic [7:0]  GOLDEN_SIG   = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] misr_sig,
    output logic [7:0] pattern,
    output logic       pattern_valid,
    output logic       misr_clr,
    output logic       busy,
    output logic       done,
`ifdef BIST_SIG_CAPTURE_EN
    output logic [7:0] sig_captured,
`endif
    output logic       pass
);

    // state   | meaning
    // IDLE    | waiting for start after reset
    // CLEAR   | one-cycle MISR clear, LFSR loaded with seed
    // RUN     | one pattern per cycle, NUM_PATTERNS cycles
    // FLUSH   | PIPE_LAT idle cycles while the CUT/MISR pipeline drains
    // COMPARE | sample misr_sig against GOLDEN_SIG
    // DONE    | result held until the next start
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_RUN, S_FLUSH, S_COMPARE, S_DONE
    } state_t;

    localparam int         CW         = $clog2(NUM_PATTERNS + 1);
    localparam int         FW         = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(NUM_PATTERNS);
    localparam logic [FW-1:0] FLUSH_LAST = FW'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
    localparam logic [7:0] SEED_EFF   = (SEED == 8'h00) ? 8'h01 : SEED;

    state_t        state_q;
    logic [7:0]    lfsr_q;
    logic [7:0]    lfsr_d;
    logic [CW-1:0] pcnt_q;
    logic [FW-1:0] fcnt_q;
    logic [7:0]    pattern_q;
    logic          pv_q;
    logic          clr_q;
    logic          busy_q;
    logic          done_q;
    logic          pass_q;
`ifdef BIST_SIG_CAPTURE_EN
    logic [7:0]    cap_q;
`endif

    // x^8+x^6+x^5+x^4+1, shifting toward the MSB
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            lfsr_q    <= SEED_EFF;
            pcnt_q    <= '0;
            fcnt_q    <= '0;
            pattern_q <= 8'h00;
            pv_q      <= 1'b0;
            clr_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
`ifdef BIST_SIG_CAPTURE_EN
            cap_q     <= 8'h00;
`endif
        end else begin
            clr_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_CLEAR;
                        clr_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        lfsr_q  <= SEED_EFF;
                        pcnt_q  <= '0;
                        fcnt_q  <= '0;
`ifdef BIST_SIG_CAPTURE_EN
                        cap_q   <= 8'h00;
`endif
                    end
                end
                S_CLEAR: begin
                    state_q   <= S_RUN;
                    pattern_q <= lfsr_q;
                    pv_q      <= 1'b1;
                    lfsr_q    <= lfsr_d;
                    pcnt_q    <= CW'(1);
                end
                S_RUN: begin
                    if (pcnt_q == CNT_LAST) begin
                        pattern_q <= 8'h00;
                        pv_q      <= 1'b0;
                        fcnt_q    <= '0;
                        state_q   <= (PIPE_LAT == 0) ? S_COMPARE : S_FLUSH;
                    end else begin
                        pattern_q <= lfsr_q;
                        lfsr_q    <= lfsr_d;
                        pcnt_q    <= pcnt_q + CW'(1);
                    end
                end
                S_FLUSH: begin
                    if (fcnt_q == FLUSH_LAST) begin
                        state_q <= S_COMPARE;
                    end else begin
                        fcnt_q <= fcnt_q + FW'(1);
                    end
                end
                S_COMPARE: begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    pass_q  <= (misr_sig == GOLDEN_SIG);
`ifdef BIST_SIG_CAPTURE_EN
                    cap_q   <= misr_sig;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pattern       = pattern_q;
    assign pattern_valid = pv_q;
    assign misr_clr      = clr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
`ifdef BIST_SIG_CAPTURE_EN
    assign sig_captured  = cap_q;
`endif

endmodule
